// File: rtl/ro_measure_sched.sv
// Measurement sequencer for the tapped ring oscillator: settles the ring on a tap, counts
// synchronised rising edges over a clk-timed gate window and hands results out via valid/ready.
module ro_measure_sched #(
    parameter int unsigned CNT_W         = 15,
    parameter int unsigned WIN_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sweep,
    input  logic [2:0]       tap_sel,
    input  logic [WIN_W-1:0] window,
    input  logic             abort,
    input  logic             osc_in,
    output logic             ring_en,
    output logic [2:0]       ring_tap,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic [2:0]       res_tap,
    output logic             res_ovf
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StGate,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               sweep_q, sweep_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [2:0]         tap_q, tap_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               s1_q, s2_q, s3_q;
    logic               rise;

    // s1/s2 resolve metastability; s3 only exists to form the edge detect.
    assign rise = s2_q & ~s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sweep_q <= 1'b0;
            win_q   <= '0;
            tap_q   <= 3'd0;
            timer_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            win_q   <= win_d;
            tap_q   <= tap_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            s1_q    <= osc_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        win_d   = win_q;
        tap_d   = tap_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sweep_d = sweep;
                    win_d   = (window == '0) ? WIN_W'(1) : window;
                    tap_d   = sweep ? 3'd0 : tap_sel;
                    timer_d = SETTLE_LOAD;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (timer_q == '0) begin
                    timer_d = TMR_W'(win_q) - TMR_W'(1);
                    state_d = StGate;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            StGate: begin
                if (rise) begin
                    if (&cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (timer_q == '0) begin
                    state_d = StDone;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    if (sweep_q && (tap_q != 3'd7)) begin
                        tap_d   = tap_q + 3'd1;
                        timer_d = SETTLE_LOAD;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = StSettle;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides every other transition, including a same-cycle handshake.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    assign ring_en   = (state_q == StSettle) || (state_q == StGate);
    assign ring_tap  = tap_q;
    assign busy      = (state_q != StIdle);
    assign res_valid = (state_q == StDone);
    assign res_count = cnt_q;
    assign res_tap   = tap_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_ro_measure_sched.sv
// Scoreboard bench for ro_measure_sched: expected results are queued at start and checked
// against each result the DUT presents; a 4-bit-counter instance covers saturation.
module tb_ro_measure_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sweep;
    logic [2:0]  tap_sel;
    logic [15:0] window;
    logic        abort;
    logic        osc_in;
    logic        res_ready;

    logic        ring_en, busy, res_valid, res_ovf;
    logic [2:0]  ring_tap, res_tap;
    logic [14:0] res_count;

    logic        ring_en_n, busy_n, res_valid_n, res_ovf_n;
    logic [2:0]  ring_tap_n, res_tap_n;
    logic [3:0]  res_count_n;

    int n_total = 0;
    int n_bad   = 0;
    int osc_period = 0;
    int osc_ph     = 0;

    typedef struct {
        logic [14:0] count;
        logic [2:0]  tap;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    ro_measure_sched #(.CNT_W(15), .WIN_W(16), .SETTLE_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sweep(sweep), .tap_sel(tap_sel),
        .window(window), .abort(abort), .osc_in(osc_in), .ring_en(ring_en),
        .ring_tap(ring_tap), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_tap(res_tap), .res_ovf(res_ovf)
    );

    ro_measure_sched #(.CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(16)) dut_n (
        .clk(clk), .rst(rst), .start(start), .sweep(sweep), .tap_sel(tap_sel),
        .window(window), .abort(abort), .osc_in(osc_in), .ring_en(ring_en_n),
        .ring_tap(ring_tap_n), .busy(busy_n), .res_valid(res_valid_n), .res_ready(res_ready),
        .res_count(res_count_n), .res_tap(res_tap_n), .res_ovf(res_ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring model: square wave of osc_period clk cycles, shifted off the clock edge.
    initial begin
        osc_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (osc_period == 0) begin
                osc_in = 1'b0;
                osc_ph = 0;
            end else begin
                osc_ph = (osc_ph + 1) % osc_period;
                osc_in = (osc_ph < osc_period / 2);
            end
        end
    end

    task automatic do_start(input logic sw, input logic [2:0] tap, input logic [15:0] win);
        @(negedge clk);
        start = 1'b1; sweep = sw; tap_sel = tap; window = win;
        @(negedge clk);
        start = 1'b0; sweep = 1'b0; tap_sel = 3'd0; window = 16'd0;
    endtask

    // k=1 is the current negedge; lat=-1 if res_valid never rises within max_cyc.
    task automatic wait_valid(input int max_cyc, output int lat);
        lat = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            if (k > 1) @(negedge clk);
            if (res_valid === 1'b1) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({ring_en, busy, res_valid, res_ovf, ring_tap, res_tap, res_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=0",
                     {ring_en, busy, res_valid, res_ovf, ring_tap, res_tap, res_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int   lat;
        exp_t e;
        osc_period = 8;
        exp_q.push_back('{count: 15'd10, tap: 3'd5, ovf: 1'b0});
        do_start(1'b0, 3'd5, 16'd80);
        n_total++;
        if (ring_en !== 1'b1 || ring_tap !== 3'd5) begin
            n_bad++;
            $display("FAIL single_ring got en=%b tap=%0d want en=1 tap=5", ring_en, ring_tap);
        end
        wait_valid(300, lat);
        n_total++;
        if (lat !== 97) begin
            n_bad++;
            $display("FAIL single_latency got=%0d want=97", lat);
        end
        e = exp_q.pop_front();
        n_total++;
        if (res_count !== e.count || res_tap !== e.tap || res_ovf !== e.ovf || ring_en !== 1'b0) begin
            n_bad++;
            $display("FAIL single_result got cnt=%0d tap=%0d ovf=%b en=%b want cnt=%0d tap=%0d ovf=%b en=0",
                     res_count, res_tap, res_ovf, ring_en, e.count, e.tap, e.ovf);
        end
        handshake();
        n_total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after_hs got valid=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_saturate();
        int   lat;
        exp_t e;
        osc_period = 4;
        exp_q.push_back('{count: 15'd25, tap: 3'd2, ovf: 1'b0});
        do_start(1'b0, 3'd2, 16'd100);
        wait_valid(300, lat);
        n_total++;
        if (lat !== 117) begin
            n_bad++;
            $display("FAIL sat_latency got=%0d want=117", lat);
        end
        e = exp_q.pop_front();
        n_total++;
        if (res_count !== e.count || res_tap !== e.tap || res_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL sat_wide got cnt=%0d tap=%0d ovf=%b want cnt=%0d tap=%0d ovf=%b",
                     res_count, res_tap, res_ovf, e.count, e.tap, e.ovf);
        end
        n_total++;
        if (res_valid_n !== 1'b1 || res_count_n !== 4'hF || res_ovf_n !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_narrow got valid=%b cnt=%0d ovf=%b want valid=1 cnt=15 ovf=1",
                     res_valid_n, res_count_n, res_ovf_n);
        end
        handshake();
    endtask

    task automatic test_sweep();
        int   lat;
        exp_t e;
        osc_period = 8;
        for (int t = 0; t < 8; t++) exp_q.push_back('{count: 15'd5, tap: 3'(t), ovf: 1'b0});
        do_start(1'b1, 3'd6, 16'd40);
        for (int t = 0; t < 8; t++) begin
            wait_valid(200, lat);
            n_total++;
            if (lat < 0) begin
                n_bad++;
                $display("FAIL sweep_timeout got=none want=result tap %0d", t);
            end
            e = exp_q.pop_front();
            for (int s = 0; s < 5; s++) begin
                n_total++;
                if (res_valid !== 1'b1 || res_count !== e.count || res_tap !== e.tap ||
                    res_ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL sweep_result got v=%b cnt=%0d tap=%0d ovf=%b want v=1 cnt=%0d tap=%0d ovf=%b",
                             res_valid, res_count, res_tap, res_ovf, e.count, e.tap, e.ovf);
                end
                @(negedge clk);
            end
            handshake();
        end
        n_total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sweep_end got busy=%b valid=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_abort();
        int seen;
        osc_period = 8;
        do_start(1'b0, 3'd4, 16'd60);
        repeat (36) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++;
        if (ring_en !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_now got en=%b busy=%b valid=%b want 0 0 0", ring_en, busy, res_valid);
        end
        seen = 0;
        repeat (120) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        n_total++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_no_result got=%0d want=0", seen);
        end
    endtask

    task automatic test_min_window();
        int   lat;
        exp_t e;
        osc_period = 0;
        repeat (4) @(negedge clk);
        exp_q.push_back('{count: 15'd0, tap: 3'd1, ovf: 1'b0});
        do_start(1'b0, 3'd1, 16'd0);
        repeat (3) @(negedge clk);
        start = 1'b1; sweep = 1'b1; tap_sel = 3'd6; window = 16'd50;
        @(negedge clk);
        start = 1'b0; sweep = 1'b0; tap_sel = 3'd0; window = 16'd0;
        n_total++;
        if (ring_en !== 1'b1 || ring_tap !== 3'd1) begin
            n_bad++;
            $display("FAIL ignore_start got en=%b tap=%0d want en=1 tap=1", ring_en, ring_tap);
        end
        wait_valid(100, lat);
        n_total++;
        if (lat + 4 !== 18) begin
            n_bad++;
            $display("FAIL minwin_latency got=%0d want=18", lat + 4);
        end
        e = exp_q.pop_front();
        n_total++;
        if (res_count !== e.count || res_tap !== e.tap || res_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL minwin_result got cnt=%0d tap=%0d ovf=%b want cnt=%0d tap=%0d ovf=%b",
                     res_count, res_tap, res_ovf, e.count, e.tap, e.ovf);
        end
        handshake();
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL minwin_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_in_done();
        int   lat;
        exp_t e;
        osc_period = 8;
        do_start(1'b0, 3'd6, 16'd24);
        wait_valid(100, lat);
        n_total++;
        if (lat !== 41 || res_count !== 15'd3) begin
            n_bad++;
            $display("FAIL pre_reset got lat=%0d cnt=%0d want lat=41 cnt=3", lat, res_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({ring_en, busy, res_valid, res_ovf, ring_tap, res_tap, res_count} !== '0) begin
            n_bad++;
            $display("FAIL done_reset got=%b want=0",
                     {ring_en, busy, res_valid, res_ovf, ring_tap, res_tap, res_count});
        end
        exp_q.push_back('{count: 15'd2, tap: 3'd3, ovf: 1'b0});
        do_start(1'b0, 3'd3, 16'd16);
        wait_valid(100, lat);
        e = exp_q.pop_front();
        n_total++;
        if (lat !== 33 || res_count !== e.count || res_tap !== e.tap || res_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL post_reset got lat=%0d cnt=%0d tap=%0d ovf=%b want lat=33 cnt=%0d tap=%0d ovf=%b",
                     lat, res_count, res_tap, res_ovf, e.count, e.tap, e.ovf);
        end
        handshake();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sweep = 1'b0; tap_sel = 3'd0; window = 16'd0;
        abort = 1'b0; res_ready = 1'b0;
        test_reset();
        test_single();
        test_saturate();
        test_sweep();
        test_abort();
        test_min_window();
        test_reset_in_done();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
